// File: rtl/dmem_mmio.sv
// dmem_mmio: data-memory responder for the single-cycle RV32 core.
// Serves every load/store the core issues: byte-enabled word RAM plus a
// small MMIO page at 0xFFFF_xxxx holding a free-running cycle counter, a
// sticky timer-compare interrupt and a debug-console transmit FIFO that is
// drained over a valid/ready handshake.
module dmem_mmio #(
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  we_dmem,
  output logic [31:0] drdata,
  output logic [7:0]  console_data,
  output logic        console_valid,
  input  logic        console_ready,
  output logic        timer_irq
);

  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int RAM_WORDS = 1 << ADDR_WIDTH;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  // Word offsets (daddr[7:2]) of the MMIO registers.
  typedef enum logic [5:0] {
    REG_CYCLE      = 6'h00,
    REG_CONSOLE_TX = 6'h01,
    REG_STATUS     = 6'h02,
    REG_TIMER_CMP  = 6'h03
  } mmio_reg_e;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic                  mmio_sel;
  logic [5:0]            reg_off;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  mmio_wr;
  logic                  unused_addr;

  assign mmio_sel = (daddr[31:16] == 16'hFFFF);
  assign reg_off  = daddr[7:2];
  assign word_idx = daddr[ADDR_WIDTH+1:2];
  // MMIO state ignores stores while reset is held; RAM does not.
  assign mmio_wr  = mmio_sel && (we_dmem != 4'b0000) && !reset;

  // Byte offset and the page bits above the register field are don't-care.
  assign unused_addr = ^{daddr[15:8], daddr[1:0]};

  // ---------------------------------------------------------------------
  // Word RAM
  // ---------------------------------------------------------------------
  logic [31:0] ram_q [RAM_WORDS];

  // Byte-lane RAM write; upper address bits alias onto the same words.
  // NOTE: storage arrays get no reset branch -- contents survive reset and
  // a reset term would force the array into flops instead of RAM.
  always_ff @(posedge clk) begin
    if (!mmio_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (we_dmem[i]) begin
          ram_q[word_idx][8*i +: 8] <= dwdata[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // MMIO state
  // ---------------------------------------------------------------------
  logic [31:0]      cycle_q, cycle_d;
  logic [31:0]      timer_cmp_q, timer_cmp_d;
  logic             timer_irq_q, timer_irq_d;
  logic             overflow_q, overflow_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] fifo_count_q, fifo_count_d;
  logic [7:0]       fifo_mem_q [FIFO_DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic fifo_pop;
  logic push_req;
  logic push_ok;
  logic overflow_set;
  logic status_wr;
  logic cmp_wr;
  logic timer_match;

  assign fifo_empty = (fifo_count_q == '0);
  assign fifo_full  = (fifo_count_q == CNT_FULL);
  assign fifo_pop   = !fifo_empty && console_ready;

  assign push_req     = mmio_wr && (reg_off == REG_CONSOLE_TX) && we_dmem[0];
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok      = push_req && (!fifo_full || fifo_pop);
  assign overflow_set = push_req && fifo_full && !fifo_pop;

  assign status_wr   = mmio_wr && (reg_off == REG_STATUS) && we_dmem[0];
  assign cmp_wr      = mmio_wr && (reg_off == REG_TIMER_CMP);
  assign timer_match = (cycle_q == timer_cmp_q);

  // Next-state for counter, timer, overflow flag and FIFO bookkeeping.
  // NOTE: every _d gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    cycle_d      = cycle_q + 32'd1;
    timer_cmp_d  = timer_cmp_q;
    timer_irq_d  = timer_irq_q;
    overflow_d   = overflow_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    fifo_count_d = fifo_count_q;

    if (cmp_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (we_dmem[i]) begin
          timer_cmp_d[8*i +: 8] = dwdata[8*i +: 8];
        end
      end
    end

    // A compare write beats a match in the same cycle.
    if (cmp_wr) begin
      timer_irq_d = 1'b0;
    end else if (timer_match) begin
      timer_irq_d = 1'b1;
    end

    if (overflow_set) begin
      overflow_d = 1'b1;
    end else if (status_wr && dwdata[2]) begin
      overflow_d = 1'b0;
    end

    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    case ({push_ok, fifo_pop})
      2'b10:   fifo_count_d = fifo_count_q + CNT_ONE;
      2'b01:   fifo_count_d = fifo_count_q - CNT_ONE;
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  // State register with synchronous reset; pending FIFO bytes are dropped.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q      <= '0;
      timer_cmp_q  <= '1;
      timer_irq_q  <= 1'b0;
      overflow_q   <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      cycle_q      <= cycle_d;
      timer_cmp_q  <= timer_cmp_d;
      timer_irq_q  <= timer_irq_d;
      overflow_q   <= overflow_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fifo_count_q <= fifo_count_d;
    end
  end

  // Console FIFO storage; push_ok is already gated off during reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem_q[wr_ptr_q] <= dwdata[7:0];
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  logic [31:0] status_word;

  assign status_word = {16'h0000, 8'(fifo_count_q), 4'h0,
                        timer_irq_q, overflow_q, fifo_full, fifo_empty};

  assign console_valid = !fifo_empty;
  assign console_data  = console_valid ? fifo_mem_q[rd_ptr_q] : 8'h00;
  assign timer_irq     = timer_irq_q;

  // Combinational load path: RAM word or MMIO register, same cycle.
  always_comb begin
    drdata = 32'h0000_0000;
    if (mmio_sel) begin
      case (reg_off)
        REG_CYCLE:     drdata = cycle_q;
        REG_STATUS:    drdata = status_word;
        REG_TIMER_CMP: drdata = timer_cmp_q;
        default:       drdata = 32'h0000_0000;
      endcase
    end else begin
      drdata = ram_q[word_idx];
    end
  end

endmodule
